// File: rtl/fa_pkg.sv
// fa_pkg: shared constants and the reference adder for fa_unit.
//   FA_DEFAULT_WIDTH : default operand width (classic 1-bit full adder)
//   FA_MAX_WIDTH     : widest legal operand width
//   fa_ref()         : {carry,sum} of a+b+cin over the low 'width' bits.
//                      The carry lands at bit 'width' and higher bits are 0.
package fa_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  function automatic logic [64:0] fa_ref(input logic [63:0]   a,
                                         input logic [63:0]   b,
                                         input logic          cin,
                                         input int unsigned   width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// fa_bit_cell: purely combinational 1-bit full adder.
//   a, b, cin : operand bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : generate | (propagate & cin)
module fa_bit_cell
  import fa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ cin;
  assign carry = (a & b) | (cin & p);

endmodule

// File: rtl/fa_unit.sv
// fa_unit: registered ripple-carry adder built from WIDTH fa_bit_cell slices.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : operands valid this cycle
//   a, b, cin   : unsigned operands and carry-in
//   sum, carry  : registered {carry,sum} = a + b + cin
//   overflow    : registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid   : registered valid, one pulse per accepted operand set
// Build option FA_UNIT_INPUT_REG_EN: adds an input register stage ahead of the
// carry chain, making latency 2 cycles with unchanged throughput.
module fa_unit
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } fa_req_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
  } fa_rsp_t;

`ifdef FA_UNIT_INPUT_REG_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  // vld_pipe[0] is one cycle after in_valid; vld_pipe[STAGES] drives out_valid.
  logic [STAGES:0] vld_pipe;
  fa_req_t         req_in;
  fa_req_t         core_req;
  logic            core_vld;
  fa_rsp_t         core_rsp;
  fa_rsp_t         rsp_q;
  logic [WIDTH:0]  c;
  logic [WIDTH-1:0] s;

  assign req_in = {a, b, cin};

  if (STAGES == 0) begin : g_vld1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= in_valid;
    end
  end else begin : g_vldn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end
  end

`ifdef FA_UNIT_INPUT_REG_EN
  fa_req_t req_q;

  // Only valid operands are captured so idle-cycle X never enters the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        req_q <= '0;
    else if (in_valid) req_q <= req_in;
  end

  assign core_req = req_q;
  assign core_vld = vld_pipe[0];
`else
  assign core_req = req_in;
  assign core_vld = in_valid;
`endif

  // Ripple-carry chain: c[i] feeds slice i, slice i produces c[i+1].
  assign c[0] = core_req.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_bit_cell u_cell (
      .a     (core_req.a[i]),
      .b     (core_req.b[i]),
      .cin   (c[i]),
      .sum   (s[i]),
      .carry (c[i+1])
    );
  end

  assign core_rsp = {s, c[WIDTH], c[WIDTH] ^ c[WIDTH-1]};

  // Results load only on valid cycles; otherwise the last result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rsp_q <= '0;
    else if (core_vld) rsp_q <= core_rsp;
  end

  assign sum       = rsp_q.sum;
  assign carry     = rsp_q.carry;
  assign overflow  = rsp_q.overflow;
  assign out_valid = vld_pipe[STAGES];

`ifndef SYNTHESIS
  logic [64:0] ref_full;
  logic [64:0] core_full;

  assign ref_full  = fa_ref(64'(core_req.a), 64'(core_req.b), core_req.cin, WIDTH);
  assign core_full = 65'({c[WIDTH], s});

  a_core_matches_ref: assert property (@(posedge clk) disable iff (!rst_n)
    core_vld |-> (core_full == ref_full));
`endif

endmodule

// File: tb/tb_fa_unit.sv
module tb_fa_unit;
  import fa_pkg::*;

`ifdef FA_UNIT_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1, s1, co1, ov1, o1v;
  logic       v4, c4, co4, ov4, o4v;
  logic [3:0] a4, b4, s4;

  fa_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .carry(co1), .overflow(ov1), .out_valid(o1v)
  );

  fa_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .sum(s4), .carry(co4), .overflow(ov4), .out_valid(o4v)
  );

  typedef struct packed {
    logic       v;
    logic       co;
    logic       ov;
    logic [3:0] s;
  } exp_t;

  // Stimulus history since the last reset, one entry per clock.
  int q1v[$], q1a[$], q1b[$], q1c[$];
  int q4v[$], q4a[$], q4b[$], q4c[$];
  int errors = 0;
  int checks = 0;

  // Expected outputs from the operand history: the latest valid entry at least
  // LAT clocks old defines sum/carry/overflow; out_valid is the entry exactly
  // LAT clocks old. Overflow is judged from the two's-complement value range.
  function automatic exp_t model(input int w, input int qv[$], input int qa[$],
                                 input int qb[$], input int qc[$]);
    exp_t e;
    int idx, tot, sa, sb, st, m, h;
    e   = '0;
    m   = 1 << w;
    h   = m / 2;
    idx = qv.size() - LAT;
    for (int j = 0; j <= idx; j++) begin
      if (qv[j] != 0) begin
        tot  = qa[j] + qb[j] + qc[j];
        e.s  = 4'(tot % m);
        e.co = (tot >= m);
        sa   = (qa[j] >= h) ? qa[j] - m : qa[j];
        sb   = (qb[j] >= h) ? qb[j] - m : qb[j];
        st   = sa + sb + qc[j];
        e.ov = (st >= h) || (st < -h);
      end
    end
    if (idx >= 0) e.v = (qv[idx] != 0);
    return e;
  endfunction

  task automatic clear_hist();
    q1v.delete(); q1a.delete(); q1b.delete(); q1c.delete();
    q4v.delete(); q4a.delete(); q4b.delete(); q4c.delete();
  endtask

  // Record what is driven now, then let one rising edge pass.
  task automatic step();
    q1v.push_back(int'(v1)); q1a.push_back(int'(a1));
    q1b.push_back(int'(b1)); q1c.push_back(int'(c1));
    q4v.push_back(int'(v4)); q4a.push_back(int'(a4));
    q4b.push_back(int'(b4)); q4c.push_back(int'(c4));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0;
    #3;
    checks++;
    if ({o1v, co1, ov1, s1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_w1: got v=%0b c=%0b o=%0b s=%0b want all 0", o1v, co1, ov1, s1);
    end
    checks++;
    if ({o4v, co4, ov4, s4} !== 7'b0) begin
      errors++;
      $display("FAIL reset_w4: got v=%0b c=%0b o=%0b s=%h want all 0", o4v, co4, ov4, s4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_hist();
  endtask

  task automatic test_exhaustive_w1();
    exp_t       e;
    logic [2:0] nb;
    logic [7:0] sum_tbl;
    logic [7:0] cry_tbl;
    int         k;
    sum_tbl = 8'b1001_0110;
    cry_tbl = 8'b1110_1000;
    v4 = 0;
    for (int n = 0; n < 8 + LAT - 1; n++) begin
      nb = 3'(n);
      v1 = (n < 8);
      {a1, b1, c1} = nb;
      step();
      e = model(1, q1v, q1a, q1b, q1c);
      checks++;
      if ({o1v, co1, ov1, s1} !== {e.v, e.co, e.ov, e.s[0]}) begin
        errors++;
        $display("FAIL w1_model n=%0d: got v=%0b c=%0b o=%0b s=%0b want v=%0b c=%0b o=%0b s=%0b",
                 n, o1v, co1, ov1, s1, e.v, e.co, e.ov, e.s[0]);
      end
      k = n - LAT + 1;
      if (k >= 0 && k < 8) begin
        checks++;
        if ({o1v, co1, s1} !== {1'b1, cry_tbl[k], sum_tbl[k]}) begin
          errors++;
          $display("FAIL w1_table abc=%0d: got v=%0b c=%0b s=%0b want v=1 c=%0b s=%0b",
                   k, o1v, co1, s1, cry_tbl[k], sum_tbl[k]);
        end
      end
    end
    v1 = 0;
  endtask

  task automatic test_w4_directed();
    logic [3:0] ta[3], tb[3], ts[3];
    logic       tc[3], tco[3], tov[3];
    exp_t       e;
    ta = '{4'hF, 4'h7, 4'hF}; tb  = '{4'h1, 4'h1, 4'hF}; tc  = '{1'b0, 1'b0, 1'b1};
    ts = '{4'h0, 4'h8, 4'hF}; tco = '{1'b1, 1'b0, 1'b1}; tov = '{1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      v4 = 1; a4 = ta[t]; b4 = tb[t]; c4 = tc[t];
      for (int k = 0; k < LAT; k++) begin
        step();
        v4 = 0;
        e = model(4, q4v, q4a, q4b, q4c);
        checks++;
        if ({o4v, co4, ov4, s4} !== {e.v, e.co, e.ov, e.s}) begin
          errors++;
          $display("FAIL w4_dir_model t=%0d k=%0d: got v=%0b c=%0b o=%0b s=%h want v=%0b c=%0b o=%0b s=%h",
                   t, k, o4v, co4, ov4, s4, e.v, e.co, e.ov, e.s);
        end
      end
      checks++;
      if ({o4v, co4, ov4, s4} !== {1'b1, tco[t], tov[t], ts[t]}) begin
        errors++;
        $display("FAIL w4_dir_const t=%0d: got v=%0b c=%0b o=%0b s=%h want v=1 c=%0b o=%0b s=%h",
                 t, o4v, co4, ov4, s4, tco[t], tov[t], ts[t]);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    v4 = 1; a4 = 4'd3; b4 = 4'd4; c4 = 1'b1;
    step();
    v4 = 0;
    for (int k = 1; k < LAT; k++) step();
    checks++;
    if ({o4v, s4} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL hold_load: got v=%0b s=%h want v=1 s=8", o4v, s4);
    end
    for (int k = 0; k < 3; k++) begin
      a4 = 'x; b4 = 'x; c4 = 'x;
      step();
      e = model(4, q4v, q4a, q4b, q4c);
      checks++;
      if ({o4v, co4, ov4, s4} !== {1'b0, 1'b0, 1'b1, 4'd8} ||
          {o4v, co4, ov4, s4} !== {e.v, e.co, e.ov, e.s}) begin
        errors++;
        $display("FAIL hold_x k=%0d: got v=%0b c=%0b o=%0b s=%h want v=0 c=0 o=1 s=8",
                 k, o4v, co4, ov4, s4);
      end
    end
    a4 = 0; b4 = 0; c4 = 0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    v4 = 1; a4 = 4'd5; b4 = 4'd6; c4 = 1'b0;
    v1 = 1; a1 = 1; b1 = 1; c1 = 1;
    step();
    v4 = 0; v1 = 0;
    for (int k = 1; k < LAT; k++) step();
    checks++;
    if ({o4v, s4} !== {1'b1, 4'hB}) begin
      errors++;
      $display("FAIL areset_pre: got v=%0b s=%h want v=1 s=b", o4v, s4);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o4v, co4, ov4, s4, o1v, co1, ov1, s1} !== 11'b0) begin
      errors++;
      $display("FAIL areset_mid: got w4 v=%0b c=%0b o=%0b s=%h w1 v=%0b c=%0b o=%0b s=%0b want all 0",
               o4v, co4, ov4, s4, o1v, co1, ov1, s1);
    end
    #1 rst_n = 1'b1;
    clear_hist();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({o4v, co4, ov4, s4, o1v, co1, ov1, s1} !== 11'b0) begin
        errors++;
        $display("FAIL areset_stay k=%0d: got w4 v=%0b s=%h w1 v=%0b s=%0b want all 0",
                 k, o4v, s4, o1v, s1);
      end
    end
    v4 = 1; a4 = 4'd2; b4 = 4'd9; c4 = 1'b1;
    step();
    v4 = 0;
    for (int k = 1; k < LAT; k++) step();
    e = model(4, q4v, q4a, q4b, q4c);
    checks++;
    if ({o4v, co4, ov4, s4} !== {e.v, e.co, e.ov, e.s} || s4 !== 4'hC) begin
      errors++;
      $display("FAIL areset_post: got v=%0b c=%0b o=%0b s=%h want v=%0b c=%0b o=%0b s=%h",
               o4v, co4, ov4, s4, e.v, e.co, e.ov, e.s);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [64:0] r;
    int          idx, cv;
    for (int n = 0; n < 10 + LAT; n++) begin
      v4 = (n < 10); a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      v1 = (n < 10); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      step();
      e = model(4, q4v, q4a, q4b, q4c);
      checks++;
      if ({o4v, co4, ov4, s4} !== {e.v, e.co, e.ov, e.s}) begin
        errors++;
        $display("FAIL b2b_w4 n=%0d: got v=%0b c=%0b o=%0b s=%h want v=%0b c=%0b o=%0b s=%h",
                 n, o4v, co4, ov4, s4, e.v, e.co, e.ov, e.s);
      end
      e = model(1, q1v, q1a, q1b, q1c);
      checks++;
      if ({o1v, co1, ov1, s1} !== {e.v, e.co, e.ov, e.s[0]}) begin
        errors++;
        $display("FAIL b2b_w1 n=%0d: got v=%0b c=%0b o=%0b s=%0b want v=%0b c=%0b o=%0b s=%0b",
                 n, o1v, co1, ov1, s1, e.v, e.co, e.ov, e.s[0]);
      end
      idx = q4v.size() - LAT;
      if (idx >= 0 && q4v[idx] != 0) begin
        cv = q4c[idx];
        r  = fa_ref(64'(q4a[idx]), 64'(q4b[idx]), cv[0], 4);
        checks++;
        if ({co4, s4} !== r[4:0]) begin
          errors++;
          $display("FAIL b2b_faref n=%0d: got %h want %h", n, {co4, s4}, r[4:0]);
        end
      end
    end
    v4 = 0; v1 = 0;
  endtask

  task automatic test_random_valid();
    exp_t e;
    for (int n = 0; n < 40; n++) begin
      v4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      step();
      e = model(4, q4v, q4a, q4b, q4c);
      checks++;
      if ({o4v, co4, ov4, s4} !== {e.v, e.co, e.ov, e.s}) begin
        errors++;
        $display("FAIL rnd_w4 n=%0d: got v=%0b c=%0b o=%0b s=%h want v=%0b c=%0b o=%0b s=%h",
                 n, o4v, co4, ov4, s4, e.v, e.co, e.ov, e.s);
      end
      e = model(1, q1v, q1a, q1b, q1c);
      checks++;
      if ({o1v, co1, ov1, s1} !== {e.v, e.co, e.ov, e.s[0]}) begin
        errors++;
        $display("FAIL rnd_w1 n=%0d: got v=%0b c=%0b o=%0b s=%0b want v=%0b c=%0b o=%0b s=%0b",
                 n, o1v, co1, ov1, s1, e.v, e.co, e.ov, e.s[0]);
      end
    end
    v4 = 0; v1 = 0;
  endtask

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_w4_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
